// File: rtl/rd_req_scheduler.sv
// Round-robin read-request scheduler: splits queued jobs into AR bursts under credit/prog_full throttling.
// Optional macro BOUNDARY_4K_SPLIT_EN keeps every burst inside one 4 KB address page.
module rd_req_scheduler #(
  parameter int NUM_REQ         = 4,
  parameter int BEAT_BYTES      = 64,
  parameter int MAX_BURST_BYTES = 1024,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    job_valid,
  input  logic [NUM_REQ*26-1:0] job_length,
  input  logic [NUM_REQ*64-1:0] job_addr,
  input  logic [NUM_REQ*16-1:0] job_id,
  output logic [NUM_REQ-1:0]    job_rd,
  input  logic                  result_prog_full,
  output logic                  ar_valid,
  input  logic                  ar_ready,
  output logic [63:0]           ar_addr,
  output logic [7:0]            ar_len,
  output logic [15:0]           ar_id,
  input  logic                  r_last,
  output logic                  busy,
  output logic                  err_underflow
);

  localparam int IDX_W      = $clog2(NUM_REQ);
  localparam int BEAT_SHIFT = $clog2(BEAT_BYTES);
  localparam int MAX_BEATS  = MAX_BURST_BYTES / BEAT_BYTES;
  localparam int CHUNK_W    = $clog2(MAX_BEATS + 1);

  typedef enum logic [1:0] {IDLE, LOAD, ISSUE, DONE} state_t;

  state_t             state_reg, state_next;
  logic [IDX_W-1:0]   rr_ptr_reg, grant_reg, grant_next;
  logic               grant_found;
  logic [IDX_W:0]     idx_sum;
  logic [63:0]        addr_reg;
  logic [26:0]        beats_reg;
  logic [15:0]        id_reg;
  logic               ar_valid_reg;
  logic [7:0]         ar_len_reg;
  logic [3:0]         outstanding_reg;
  logic               err_reg;

  logic [25:0] len_arr  [NUM_REQ];
  logic [63:0] addr_arr [NUM_REQ];
  logic [15:0] id_arr   [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign len_arr[gi]  = job_length[26*gi +: 26];
    assign addr_arr[gi] = job_addr[64*gi +: 64];
    assign id_arr[gi]   = job_id[16*gi +: 16];
  end

  logic [63:0]        load_addr;
  logic [26:0]        load_beats;
  logic [26:0]        room_load, room_cur;
  logic [CHUNK_W-1:0] load_chunk, cur_chunk;
  logic               can_issue, handshake;

  assign load_addr  = addr_arr[grant_reg] & ~64'(BEAT_BYTES - 1);
  assign load_beats = ({1'b0, len_arr[grant_reg]} + 27'(BEAT_BYTES - 1)) >> BEAT_SHIFT;

`ifdef BOUNDARY_4K_SPLIT_EN
  // Beats left before the next 4 KB page; addresses are beat aligned so this divides exactly.
  assign room_load = 27'((13'd4096 - {1'b0, load_addr[11:0]}) >> BEAT_SHIFT);
  assign room_cur  = 27'((13'd4096 - {1'b0, addr_reg[11:0]}) >> BEAT_SHIFT);
`else
  assign room_load = 27'(MAX_BEATS);
  assign room_cur  = 27'(MAX_BEATS);
`endif

  function automatic logic [CHUNK_W-1:0] chunk_of(input logic [26:0] beats, input logic [26:0] room);
    logic [26:0] lim;
    lim = (room < 27'(MAX_BEATS)) ? room : 27'(MAX_BEATS);
    return (beats < lim) ? CHUNK_W'(beats) : CHUNK_W'(lim);
  endfunction

  assign load_chunk = chunk_of(load_beats, room_load);
  assign cur_chunk  = chunk_of(beats_reg, room_cur);
  assign can_issue  = (outstanding_reg < 4'(MAX_OUTSTANDING)) && !result_prog_full;
  assign handshake  = (state_reg == ISSUE) && ar_valid_reg && ar_ready;

  // Iterate downwards so the closest requester at or after rr_ptr wins.
  always_comb begin
    grant_found = 1'b0;
    grant_next  = rr_ptr_reg;
    idx_sum     = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx_sum = {1'b0, rr_ptr_reg} + (IDX_W + 1)'(k);
      if (idx_sum >= (IDX_W + 1)'(NUM_REQ))
        idx_sum = idx_sum - (IDX_W + 1)'(NUM_REQ);
      if (job_valid[idx_sum[IDX_W-1:0]]) begin
        grant_found = 1'b1;
        grant_next  = idx_sum[IDX_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    job_rd     = '0;
    case (state_reg)
      IDLE:  if (grant_found) state_next = LOAD;
      LOAD:  state_next = (load_beats == '0) ? DONE : ISSUE;
      ISSUE: if (handshake && beats_reg == 27'(cur_chunk)) state_next = DONE;
      DONE: begin
        job_rd[grant_reg] = 1'b1;
        state_next        = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_reg   <= '0;
      grant_reg    <= '0;
      addr_reg     <= '0;
      beats_reg    <= '0;
      id_reg       <= '0;
      ar_valid_reg <= 1'b0;
      ar_len_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: if (grant_found) grant_reg <= grant_next;
        LOAD: begin
          addr_reg  <= load_addr;
          beats_reg <= load_beats;
          id_reg    <= id_arr[grant_reg];
          if (load_beats != '0 && can_issue) begin
            ar_valid_reg <= 1'b1;
            ar_len_reg   <= 8'(load_chunk - 1'b1);
          end
        end
        ISSUE: begin
          if (ar_valid_reg && ar_ready) begin
            ar_valid_reg <= 1'b0;
            addr_reg     <= addr_reg + (64'(cur_chunk) << BEAT_SHIFT);
            beats_reg    <= beats_reg - 27'(cur_chunk);
          end else if (!ar_valid_reg && can_issue) begin
            // Throttle is sampled only while low; once raised the request holds until accepted.
            ar_valid_reg <= 1'b1;
            ar_len_reg   <= 8'(cur_chunk - 1'b1);
          end
        end
        DONE: rr_ptr_reg <= (grant_reg == IDX_W'(NUM_REQ - 1)) ? '0 : grant_reg + 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outstanding_reg <= '0;
      err_reg         <= 1'b0;
    end else if (handshake && !r_last) begin
      outstanding_reg <= outstanding_reg + 1'b1;
    end else if (r_last && !handshake) begin
      if (outstanding_reg == '0) err_reg <= 1'b1;
      else                       outstanding_reg <= outstanding_reg - 1'b1;
    end
  end

  assign ar_valid      = ar_valid_reg;
  assign ar_addr       = addr_reg;
  assign ar_len        = ar_len_reg;
  assign ar_id         = id_reg;
  assign busy          = (state_reg != IDLE) || (outstanding_reg != '0);
  assign err_underflow = err_reg;

endmodule

// File: tb/tb_rd_req_scheduler.sv
// Directed self-checking bench for rd_req_scheduler (default parameters, NUM_REQ=4).
module tb_rd_req_scheduler;
  localparam int N = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  job_valid;
  logic [N*26-1:0] job_length;
  logic [N*64-1:0] job_addr;
  logic [N*16-1:0] job_id;
  logic [N-1:0]  job_rd;
  logic          result_prog_full;
  logic          ar_valid, ar_ready;
  logic [63:0]   ar_addr;
  logic [7:0]    ar_len;
  logic [15:0]   ar_id;
  logic          r_last, busy, err_underflow;

  int checks = 0;
  int failures = 0;

  logic [63:0] hs_addr [$];
  logic [7:0]  hs_len  [$];
  logic [15:0] hs_id   [$];
  logic [3:0]  rd_val  [$];
  int          rd_at_hs[$];

  rd_req_scheduler dut (
    .clk(clk), .rst_n(rst_n), .job_valid(job_valid), .job_length(job_length),
    .job_addr(job_addr), .job_id(job_id), .job_rd(job_rd),
    .result_prog_full(result_prog_full), .ar_valid(ar_valid), .ar_ready(ar_ready),
    .ar_addr(ar_addr), .ar_len(ar_len), .ar_id(ar_id), .r_last(r_last),
    .busy(busy), .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_job(input int q, input logic [25:0] len, input logic [63:0] addr, input logic [15:0] id);
    job_length[26*q +: 26] = len;
    job_addr[64*q +: 64]   = addr;
    job_id[16*q +: 16]     = id;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    job_valid = '0; job_length = '0; job_addr = '0; job_id = '0;
    result_prog_full = 1'b0; ar_ready = 1'b0; r_last = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    step();
    hs_addr.delete(); hs_len.delete(); hs_id.delete(); rd_val.delete(); rd_at_hs.delete();
  endtask

  // Records handshakes and pops; stop targets of 0/0 mean run the full cycle count.
  task automatic run(input int cycles, input int stop_hs, input int stop_rd, input bit clear_on_rd);
    bit done_flag = 1'b0;
    bit prev_hs = 1'b0;
    for (int c = 0; c < cycles && !done_flag; c++) begin
      if (prev_hs) begin
        checks++;
        if (ar_valid !== 1'b0) begin
          failures++;
          $display("FAIL burst_gap: ar_valid=%b required 0 in cycle after handshake", ar_valid);
        end
      end
      prev_hs = ar_valid && ar_ready;
      if (prev_hs) begin
        hs_addr.push_back(ar_addr); hs_len.push_back(ar_len); hs_id.push_back(ar_id);
        $display("burst addr=%0h len=%0d id=%0h", ar_addr, ar_len, ar_id);
      end
      if (job_rd != '0) begin
        rd_val.push_back(job_rd);
        rd_at_hs.push_back(hs_addr.size());
        $display("pop job_rd=%b after %0d bursts", job_rd, hs_addr.size());
        if (clear_on_rd) job_valid = job_valid & ~job_rd;
      end
      if ((stop_hs > 0 || stop_rd > 0) && hs_addr.size() >= stop_hs && rd_val.size() >= stop_rd)
        done_flag = 1'b1;
      step();
    end
    if (stop_hs > 0 || stop_rd > 0) begin
      checks++;
      if (!done_flag) begin
        failures++;
        $display("FAIL run_timeout: got %0d bursts %0d pops, required %0d and %0d", hs_addr.size(), rd_val.size(), stop_hs, stop_rd);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    job_valid = '0; result_prog_full = 1'b0; ar_ready = 1'b0; r_last = 1'b0;
    job_length = '0; job_addr = '0; job_id = '0;
    step();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({ar_valid, job_rd, busy, err_underflow} !== 7'b0 || ar_addr !== 64'h0 || ar_len !== 8'h0 || ar_id !== 16'h0) begin
      failures++;
      $display("FAIL reset_outputs: valid=%b rd=%b busy=%b err=%b addr=%0h len=%0h id=%0h required all 0",
               ar_valid, job_rd, busy, err_underflow, ar_addr, ar_len, ar_id);
    end
    $display("reset checked");
  endtask

  task automatic test_single_job();
    logic [63:0] exp_addr [3];
    logic [7:0]  exp_len  [3];
    exp_addr[0] = 64'h1000; exp_addr[1] = 64'h1400; exp_addr[2] = 64'h1800;
    exp_len[0] = 8'd15; exp_len[1] = 8'd15; exp_len[2] = 8'd14;
    do_reset();
    set_job(0, 26'd3000, 64'h1000, 16'h0011);
    ar_ready = 1'b1;
    job_valid = 4'b0001;
    step();
    checks++;
    if (ar_valid !== 1'b0) begin failures++; $display("FAIL latency_1cyc: ar_valid=%b required 0", ar_valid); end
    step();
    checks++;
    if (ar_valid !== 1'b1 || ar_addr !== 64'h1000 || ar_len !== 8'd15 || ar_id !== 16'h0011) begin
      failures++;
      $display("FAIL latency_2cyc: valid=%b addr=%0h len=%0d id=%0h required 1 1000 15 11", ar_valid, ar_addr, ar_len, ar_id);
    end
    run(100, 3, 1, 1'b1);
    checks++;
    if (hs_addr.size() !== 3) begin failures++; $display("FAIL single_count: got %0d bursts required 3", hs_addr.size()); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (hs_addr.size() <= i || hs_addr[i] !== exp_addr[i] || hs_len[i] !== exp_len[i]) begin
        failures++;
        $display("FAIL single_burst%0d: got addr=%0h len=%0d required addr=%0h len=%0d",
                 i, (hs_addr.size() > i) ? hs_addr[i] : 64'h0, (hs_len.size() > i) ? hs_len[i] : 8'h0, exp_addr[i], exp_len[i]);
      end
    end
    checks++;
    if (rd_val.size() < 1 || rd_val[0] !== 4'b0001 || rd_at_hs[0] !== 3) begin
      failures++;
      $display("FAIL single_pop: got %0d pops, first=%b after %0d bursts, required 0001 after 3",
               rd_val.size(), (rd_val.size() > 0) ? rd_val[0] : 4'h0, (rd_at_hs.size() > 0) ? rd_at_hs[0] : -1);
    end
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL busy_outstanding: busy=%b required 1", busy); end
    repeat (3) begin
      r_last = 1'b1; step(); r_last = 1'b0; step();
    end
    checks++;
    if (busy !== 1'b0 || err_underflow !== 1'b0) begin
      failures++;
      $display("FAIL drain: busy=%b err=%b required 0 0", busy, err_underflow);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int q = 0; q < N; q++) set_job(q, 26'd64, 64'(q) << 16, 16'h00A0 + 16'(q));
    ar_ready = 1'b1;
    job_valid = 4'hF;
    run(200, 6, 6, 1'b0);
    job_valid = '0;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (hs_id.size() <= i || hs_id[i] !== 16'h00A0 + 16'(i % 4) || hs_addr[i] !== (64'(i % 4) << 16) || hs_len[i] !== 8'd0) begin
        failures++;
        $display("FAIL rr_burst%0d: got id=%0h addr=%0h len=%0d required id=%0h addr=%0h len=0", i,
                 (hs_id.size() > i) ? hs_id[i] : 16'h0, (hs_addr.size() > i) ? hs_addr[i] : 64'h0,
                 (hs_len.size() > i) ? hs_len[i] : 8'h0, 16'h00A0 + 16'(i % 4), 64'(i % 4) << 16);
      end
      checks++;
      if (rd_val.size() <= i || rd_val[i] !== (4'b0001 << (i % 4)) || rd_at_hs[i] !== i + 1) begin
        failures++;
        $display("FAIL rr_pop%0d: got rd=%b after %0d bursts required %b after %0d", i,
                 (rd_val.size() > i) ? rd_val[i] : 4'h0, (rd_at_hs.size() > i) ? rd_at_hs[i] : -1,
                 4'b0001 << (i % 4), i + 1);
      end
    end
  endtask

  task automatic test_outstanding();
    do_reset();
    set_job(0, 26'd16384, 64'h0, 16'h0033);
    ar_ready = 1'b1;
    job_valid = 4'b0001;
    run(60, 0, 0, 1'b0);
    checks++;
    if (hs_addr.size() !== 8 || ar_valid !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL credit_stall: got %0d bursts valid=%b busy=%b required 8 0 1", hs_addr.size(), ar_valid, busy);
    end
    checks++;
    if (hs_addr.size() < 8 || hs_addr[7] !== 64'h1C00) begin
      failures++;
      $display("FAIL credit_addr8: got %0h required 1c00", (hs_addr.size() > 7) ? hs_addr[7] : 64'h0);
    end
    r_last = 1'b1; step(); r_last = 1'b0;
    run(30, 0, 0, 1'b0);
    checks++;
    if (hs_addr.size() !== 9 || hs_addr[8] !== 64'h2000 || hs_len[8] !== 8'd15) begin
      failures++;
      $display("FAIL credit_release: got %0d bursts last addr=%0h required 9 bursts addr 2000 len 15",
               hs_addr.size(), (hs_addr.size() > 8) ? hs_addr[8] : 64'h0);
    end
  endtask

  task automatic test_prog_full();
    do_reset();
    result_prog_full = 1'b1;
    set_job(1, 26'd128, 64'h2047, 16'h0055);
    job_valid = 4'b0010;
    repeat (6) step();
    checks++;
    if (ar_valid !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL pf_block: valid=%b busy=%b required 0 1", ar_valid, busy);
    end
    result_prog_full = 1'b0;
    step();
    checks++;
    if (ar_valid !== 1'b1 || ar_addr !== 64'h2040 || ar_len !== 8'd1 || ar_id !== 16'h0055) begin
      failures++;
      $display("FAIL pf_release: valid=%b addr=%0h len=%0d id=%0h required 1 2040 1 55", ar_valid, ar_addr, ar_len, ar_id);
    end
    result_prog_full = 1'b1;
    repeat (3) step();
    checks++;
    if (ar_valid !== 1'b1 || ar_addr !== 64'h2040 || ar_len !== 8'd1) begin
      failures++;
      $display("FAIL pf_hold: valid=%b addr=%0h len=%0d required 1 2040 1", ar_valid, ar_addr, ar_len);
    end
    ar_ready = 1'b1;
    step();
    checks++;
    if (ar_valid !== 1'b0 || job_rd !== 4'b0010) begin
      failures++;
      $display("FAIL pf_accept: valid=%b rd=%b required 0 0010", ar_valid, job_rd);
    end
    job_valid = '0; ar_ready = 1'b0; result_prog_full = 1'b0;
    step();
    checks++;
    if (job_rd !== 4'b0000) begin failures++; $display("FAIL pf_pop_width: rd=%b required 0000", job_rd); end
  endtask

  task automatic test_zero_len();
    do_reset();
    set_job(2, 26'd0, 64'h123, 16'h0007);
    job_valid = 4'b0100;
    step();
    checks++;
    if (job_rd !== 4'b0000 || ar_valid !== 1'b0) begin
      failures++; $display("FAIL zero_load: rd=%b valid=%b required 0000 0", job_rd, ar_valid);
    end
    step();
    checks++;
    if (job_rd !== 4'b0100 || ar_valid !== 1'b0) begin
      failures++; $display("FAIL zero_pop: rd=%b valid=%b required 0100 0", job_rd, ar_valid);
    end
    job_valid = '0;
    step();
    checks++;
    if (job_rd !== 4'b0000 || busy !== 1'b0 || err_underflow !== 1'b0) begin
      failures++; $display("FAIL zero_idle: rd=%b busy=%b err=%b required 0000 0 0", job_rd, busy, err_underflow);
    end
    r_last = 1'b1; step(); r_last = 1'b0;
    checks++;
    if (err_underflow !== 1'b1) begin failures++; $display("FAIL underflow_set: err=%b required 1", err_underflow); end
    repeat (3) step();
    checks++;
    if (err_underflow !== 1'b1 || busy !== 1'b0) begin
      failures++; $display("FAIL underflow_sticky: err=%b busy=%b required 1 0", err_underflow, busy);
    end
  endtask

  task automatic test_ceil_lengths();
    logic [25:0] lens  [4];
    logic [7:0]  first [4];
    int          nb    [4];
    lens[0] = 26'd1;   first[0] = 8'd0;  nb[0] = 1;
    lens[1] = 26'd64;  first[1] = 8'd0;  nb[1] = 1;
    lens[2] = 26'd65;  first[2] = 8'd1;  nb[2] = 1;
    lens[3] = 26'd1025; first[3] = 8'd15; nb[3] = 2;
    for (int v = 0; v < 4; v++) begin
      do_reset();
      set_job(0, lens[v], 64'h40, 16'h0100 + 16'(v));
      ar_ready = 1'b1;
      job_valid = 4'b0001;
      run(80, nb[v], 1, 1'b1);
      checks++;
      if (hs_len.size() !== nb[v] || hs_len[0] !== first[v]) begin
        failures++;
        $display("FAIL ceil_len%0d: got %0d bursts first len=%0d required %0d bursts len=%0d",
                 lens[v], hs_len.size(), (hs_len.size() > 0) ? hs_len[0] : 8'h0, nb[v], first[v]);
      end
    end
  endtask

  task automatic test_4k_and_reset();
    do_reset();
    set_job(3, 26'd512, 64'hF80, 16'h0033);
    ar_ready = 1'b1;
    job_valid = 4'b1000;
`ifdef BOUNDARY_4K_SPLIT_EN
    run(100, 2, 1, 1'b1);
    checks++;
    if (hs_addr.size() !== 2 || hs_addr[0] !== 64'hF80 || hs_len[0] !== 8'd1 ||
        hs_addr[1] !== 64'h1000 || hs_len[1] !== 8'd5) begin
      failures++;
      $display("FAIL split_4k: got %0d bursts required (f80,1),(1000,5)", hs_addr.size());
    end
`else
    run(100, 1, 1, 1'b1);
    checks++;
    if (hs_addr.size() !== 1 || hs_addr[0] !== 64'hF80 || hs_len[0] !== 8'd7) begin
      failures++;
      $display("FAIL cross_4k: got %0d bursts first len=%0d required one burst (f80,7)",
               hs_addr.size(), (hs_len.size() > 0) ? hs_len[0] : 8'h0);
    end
`endif
    checks++;
    if (rd_val.size() < 1 || rd_val[0] !== 4'b1000) begin
      failures++;
      $display("FAIL q3_pop: got %0d pops first=%b required 1000", rd_val.size(), (rd_val.size() > 0) ? rd_val[0] : 4'h0);
    end
    set_job(0, 26'd16384, 64'h4000, 16'h0044);
    ar_ready = 1'b0;
    job_valid = 4'b0001;
    repeat (3) step();
    checks++;
    if (ar_valid !== 1'b1) begin failures++; $display("FAIL midissue_valid: valid=%b required 1", ar_valid); end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({ar_valid, job_rd, busy, err_underflow} !== 7'b0 || ar_addr !== 64'h0 || ar_len !== 8'h0 || ar_id !== 16'h0) begin
      failures++;
      $display("FAIL midissue_reset: valid=%b rd=%b busy=%b addr=%0h len=%0d id=%0h required all 0",
               ar_valid, job_rd, busy, ar_addr, ar_len, ar_id);
    end
    job_valid = '0;
    step();
    rst_n = 1'b1;
    begin
      logic [3:0] rd_seen = 4'b0;
      logic       busy_seen = 1'b0;
      repeat (6) begin
        step();
        rd_seen   = rd_seen | job_rd;
        busy_seen = busy_seen | busy;
      end
      checks++;
      if (rd_seen !== 4'b0 || busy_seen !== 1'b0) begin
        failures++;
        $display("FAIL abandon_job: rd_seen=%b busy_seen=%b required 0000 0", rd_seen, busy_seen);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_job();
    test_round_robin();
    test_outstanding();
    test_prog_full();
    test_zero_len();
    test_ceil_lengths();
    test_4k_and_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
